nexys_starship_game_ctrl: RTL and testbench

- Top-level game sequencer that feeds all four monster terminals (left, right, top, bottom) and consumes their status.
- Generates play_flag, gameover_ctrl, the slow timer_clk and per-terminal random bits.
- Collects the terminals' monster and gameover lines to run the INIT/PLAY/OVER flow and keep the score and high score.

---
 rtl/nexys_starship_game_ctrl.sv | 151 +++++++++++++++
 tb/tb_nexys_starship_game_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_game_ctrl.sv
// Game sequencer for the four monster terminals: runs INIT/PLAY/OVER, keeps score and
// high score, and supplies the shared timer clock and per-terminal random bits.
module nexys_starship_game_ctrl #(
    parameter int          TIMER_HALF = 50_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          SCORE_W    = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start_btn,
    input  logic [3:0]         monster_gameover,
    input  logic [3:0]         monster,
    output logic               play_flag,
    output logic               gameover_ctrl,
    output logic               timer_clk,
    output logic [3:0]         random,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               q_Init,
    output logic               q_Play,
    output logic               q_Over
);

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam int              CNT_W    = (TIMER_HALF > 1) ? $clog2(TIMER_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMER_HALF - 1);

    function automatic logic [2:0] count4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Saturating add so a long game pins at the maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [2:0] b);
        logic [SCORE_W+2:0] s;
        s = {3'b000, a} + {{SCORE_W{1'b0}}, b};
        if (s > {3'b000, {SCORE_W{1'b1}}}) begin
            return {SCORE_W{1'b1}};
        end else begin
            return s[SCORE_W-1:0];
        end
    endfunction

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [3:0]         hist_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tclk_q, tclk_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [3:0]         random_q, random_d;
    logic               play_q, over_q, init_q;
    logic [2:0]         falls_s;

    assign falls_s = count4(hist_q & ~monster);

    // Game flow, scoring and high-score capture on OVER entry.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        case (state_q)
            ST_INIT: begin
                if (start_btn) begin
                    state_d = ST_PLAY;
                    score_d = {SCORE_W{1'b0}};
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_PLAY: begin
                if (|monster_gameover) begin
                    state_d = ST_OVER;
                    if (score_q > high_q) begin
                        high_d = score_q;
                    end else begin
                        high_d = high_q;
                    end
                end else begin
                    score_d = sat_add(score_q, falls_s);
                end
            end
            ST_OVER: begin
                if (start_btn) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Free-running timer divider and LFSR.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d  = {CNT_W{1'b0}};
            tclk_d = ~tclk_q;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tclk_d = tclk_q;
        end
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        random_d = {lfsr_d[15], lfsr_d[10], lfsr_d[5], lfsr_d[0]};
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_INIT;
            score_q  <= {SCORE_W{1'b0}};
            high_q   <= {SCORE_W{1'b0}};
            hist_q   <= 4'b0000;
            cnt_q    <= {CNT_W{1'b0}};
            tclk_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            random_q <= {LFSR_SEED[15], LFSR_SEED[10], LFSR_SEED[5], LFSR_SEED[0]};
            play_q   <= 1'b0;
            over_q   <= 1'b0;
            init_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            high_q   <= high_d;
            hist_q   <= monster;
            cnt_q    <= cnt_d;
            tclk_q   <= tclk_d;
            lfsr_q   <= lfsr_d;
            random_q <= random_d;
            play_q   <= (state_d == ST_PLAY);
            over_q   <= (state_d == ST_OVER);
            init_q   <= (state_d == ST_INIT);
        end
    end

    assign play_flag     = play_q;
    assign gameover_ctrl = over_q;
    assign q_Play        = play_q;
    assign q_Over        = over_q;
    assign q_Init        = init_q;
    assign timer_clk     = tclk_q;
    assign random        = random_q;
    assign score         = score_q;
    assign high_score    = high_q;

endmodule

// File: tb/tb_nexys_starship_game_ctrl.sv
// Bench for nexys_starship_game_ctrl: directed scenarios plus a randomized run against
// a behavioural game model.
module tb_nexys_starship_game_ctrl;

    localparam int SW   = 3;
    localparam int TH   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          Clk, Reset, start_btn;
    logic [3:0]    monster_gameover, monster;
    logic          play_flag, gameover_ctrl, timer_clk;
    logic [3:0]    random;
    logic [SW-1:0] score, high_score;
    logic          q_Init, q_Play, q_Over;

    int total = 0;
    int bad   = 0;

    // behavioural model: 0=INIT 1=PLAY 2=OVER
    int          m_state, m_score, m_high, m_tcnt;
    logic        m_tclk;
    logic [3:0]  m_hist, m_random;
    logic [15:0] m_lfsr;

    nexys_starship_game_ctrl #(.TIMER_HALF(TH), .LFSR_SEED(16'hACE1), .SCORE_W(SW)) dut (
        .Clk(Clk), .Reset(Reset), .start_btn(start_btn),
        .monster_gameover(monster_gameover), .monster(monster),
        .play_flag(play_flag), .gameover_ctrl(gameover_ctrl), .timer_clk(timer_clk),
        .random(random), .score(score), .high_score(high_score),
        .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_tcnt = 0; m_tclk = 1'b0;
        m_hist = 4'b0000; m_lfsr = 16'hACE1;
        m_random = {m_lfsr[15], m_lfsr[10], m_lfsr[5], m_lfsr[0]};
    endtask

    task automatic model_step();
        int falls;
        falls = 0;
        for (int i = 0; i < 4; i++) if (m_hist[i] && !monster[i]) falls++;
        if (m_state == 0) begin
            if (start_btn) begin m_state = 1; m_score = 0; end
        end else if (m_state == 1) begin
            if (monster_gameover != 4'b0000) begin
                m_state = 2;
                if (m_score > m_high) m_high = m_score;
            end else begin
                m_score = (m_score + falls > SMAX) ? SMAX : m_score + falls;
            end
        end else begin
            if (start_btn) m_state = 0;
        end
        m_hist = monster;
        if (m_tcnt == TH - 1) begin m_tcnt = 0; m_tclk = ~m_tclk; end
        else m_tcnt = m_tcnt + 1;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_random = {m_lfsr[15], m_lfsr[10], m_lfsr[5], m_lfsr[0]};
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic clear_pair(input logic [3:0] m);
        monster = m; cycle();
        monster = 4'b0000; cycle();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cycle(); cycle();
        total++; if (q_Init !== 1'b1) begin bad++; $display("FAIL reset_q_init got=%b exp=1", q_Init); end
        total++; if (play_flag !== 1'b0 || gameover_ctrl !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", play_flag, gameover_ctrl); end
        total++; if (score !== 3'd0 || high_score !== 3'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score, high_score); end
        total++; if (random !== 4'b1111) begin bad++; $display("FAIL reset_random got=%b exp=1111", random); end
        total++; if (timer_clk !== 1'b0) begin bad++; $display("FAIL reset_timer got=%b exp=0", timer_clk); end
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        total++; if (q_Init !== 1'b1 || play_flag !== 1'b0) begin bad++; $display("FAIL idle_init got=%b%b exp=10", q_Init, play_flag); end
        total++; if (random !== m_random) begin bad++; $display("FAIL idle_random got=%b exp=%b", random, m_random); end
    endtask

    task automatic test_timer();
        logic exp;
        Reset = 1'b1; cycle(); Reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            exp = ((k / TH) % 2) == 1;
            total++; if (timer_clk !== exp) begin bad++; $display("FAIL timer_k%0d got=%b exp=%b", k, timer_clk, exp); end
        end
    endtask

    task automatic test_play();
        start_btn = 1'b1; cycle(); start_btn = 1'b0;
        total++; if (play_flag !== 1'b1 || q_Play !== 1'b1) begin bad++; $display("FAIL play_entry got=%b%b exp=11", play_flag, q_Play); end
        clear_pair(4'b0101);
        total++; if (score !== 3'd2) begin bad++; $display("FAIL score_two got=%0d exp=2", score); end
        clear_pair(4'b1111);
        total++; if (score !== 3'd6) begin bad++; $display("FAIL score_six got=%0d exp=6", score); end
    endtask

    task automatic test_gameover_priority();
        monster = 4'b0010; cycle();
        monster_gameover = 4'b0010; monster = 4'b0000; cycle();
        monster_gameover = 4'b0000;
        total++; if (q_Over !== 1'b1 || gameover_ctrl !== 1'b1 || play_flag !== 1'b0) begin bad++; $display("FAIL over_entry got=%b%b%b exp=110", q_Over, gameover_ctrl, play_flag); end
        total++; if (score !== 3'd6) begin bad++; $display("FAIL over_score got=%0d exp=6", score); end
        total++; if (high_score !== 3'd6) begin bad++; $display("FAIL high_six got=%0d exp=6", high_score); end
    endtask

    task automatic test_second_game();
        start_btn = 1'b1; cycle();
        total++; if (q_Init !== 1'b1 || score !== 3'd6) begin bad++; $display("FAIL over_to_init got=%b/%0d exp=1/6", q_Init, score); end
        cycle(); start_btn = 1'b0;
        total++; if (score !== 3'd0 || q_Play !== 1'b1) begin bad++; $display("FAIL score_clear got=%0d/%b exp=0/1", score, q_Play); end
        clear_pair(4'b0111);
        monster_gameover = 4'b1000; cycle(); monster_gameover = 4'b0000;
        total++; if (high_score !== 3'd6 || score !== 3'd3) begin bad++; $display("FAIL high_kept got=%0d/%0d exp=6/3", high_score, score); end
        start_btn = 1'b1; cycle(); cycle(); start_btn = 1'b0;
        clear_pair(4'b1111);
        clear_pair(4'b0111);
        monster_gameover = 4'b0001; cycle(); monster_gameover = 4'b0000;
        total++; if (high_score !== 3'd7) begin bad++; $display("FAIL high_seven got=%0d exp=7", high_score); end
    endtask

    task automatic test_back_to_back();
        start_btn = 1'b1; cycle(); cycle();
        monster_gameover = 4'b1111; cycle();
        start_btn = 1'b0; monster_gameover = 4'b0000;
        total++; if (q_Over !== 1'b1) begin bad++; $display("FAIL start_and_gameover got=%b exp=1", q_Over); end
    endtask

    task automatic test_saturate();
        start_btn = 1'b1; cycle(); cycle(); start_btn = 1'b0;
        clear_pair(4'b1111);
        clear_pair(4'b1111);
        clear_pair(4'b0001);
        total++; if (score !== 3'd7) begin bad++; $display("FAIL saturate got=%0d exp=7", score); end
        #2 Reset = 1'b1; #1;
        total++; if (q_Init !== 1'b1 || score !== 3'd0 || high_score !== 3'd0) begin bad++; $display("FAIL mid_reset got=%b/%0d/%0d exp=1/0/0", q_Init, score, high_score); end
        cycle(); Reset = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            start_btn        = ($urandom_range(0, 5) == 0);
            monster_gameover = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
            monster          = 4'($urandom);
            cycle();
            total++; if ({q_Init, q_Play, q_Over} !== {m_state == 0, m_state == 1, m_state == 2}) begin bad++; $display("FAIL rand_state n=%0d got=%b%b%b model=%0d", n, q_Init, q_Play, q_Over, m_state); end
            total++; if (play_flag !== (m_state == 1) || gameover_ctrl !== (m_state == 2)) begin bad++; $display("FAIL rand_flags n=%0d got=%b%b model=%0d", n, play_flag, gameover_ctrl, m_state); end
            total++; if (score !== SW'(m_score) || high_score !== SW'(m_high)) begin bad++; $display("FAIL rand_score n=%0d got=%0d/%0d exp=%0d/%0d", n, score, high_score, m_score, m_high); end
            total++; if (random !== m_random || timer_clk !== m_tclk) begin bad++; $display("FAIL rand_aux n=%0d got=%b/%b exp=%b/%b", n, random, timer_clk, m_random, m_tclk); end
        end
        start_btn = 1'b0; monster_gameover = 4'b0000; monster = 4'b0000;
    endtask

    initial begin
        Clk = 1'b0; Reset = 1'b1; start_btn = 1'b0;
        monster_gameover = 4'b0000; monster = 4'b0000;
        model_reset();
        test_reset();
        test_timer();
        test_play();
        test_gameover_priority();
        test_second_game();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
